// File: rtl/aes128_enc_iter.sv
// aes128_enc_iter: iterative AES-128 encryptor with valid/ready handshakes on
// both sides.
//
// The ten AES-128 rounds run over 10/UNROLL clock edges. UNROLL round slots
// sit back to back in one combinational step. Round keys are expanded on the
// fly, one key per slot, so only the current round key is stored.
//
// Parameters
//   UNROLL     rounds per clock; legal values are 1, 2, 5 and 10.
//   RCON_INIT  first round constant (8'h01 for real AES); exposed for test.
//
// Optional feature macro
//   AES_CBC_EN  adds the iv_in/iv_load ports and a 128-bit chain register.
//               The chain is XORed into the plaintext when a block is
//               accepted and is reloaded with each finished ciphertext.
//
// Ports
//   clk        system clock; all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   data_in/key_in are valid
//   in_ready   core can accept a block (IDLE only)
//   data_in    plaintext, bit 127 = MSB of the first FIPS-197 byte
//   key_in     cipher key, same byte order
//   out_valid  data_out holds a finished ciphertext
//   out_ready  consumer accepts data_out
//   data_out   ciphertext; only meaningful while out_valid = 1
//   busy       high in RUN and DONE
//   iv_in      chaining IV            (AES_CBC_EN only)
//   iv_load    load iv_in into chain  (AES_CBC_EN only)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds its data stable while valid is high and
// ready is low. in_ready and out_valid depend only on registered state
// (and on iv_load when AES_CBC_EN is defined).

module aes128_enc_iter #(
    parameter int unsigned UNROLL    = 1,
    parameter logic [7:0]  RCON_INIT = 8'h01
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
`ifdef AES_CBC_EN
    input  logic [127:0] iv_in,
    input  logic         iv_load,
`endif
    output logic         busy
);

    // Ten rounds must split evenly so that round 10 always lands in the
    // last slot of the final step.
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
        $error("aes128_enc_iter: UNROLL must be 1, 2, 5 or 10");
    end

    // ------------------------------------------------------------------
    // Round primitives (sub_byte, shift_row, mix_col and key schedule)
    // ------------------------------------------------------------------

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box computed as multiplicative inverse (x^254, which maps 0 to 0)
    // followed by the FIPS-197 affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
    endfunction

    // Byte k of the state lives at bits [127-8k -: 8]; byte k is row k%4,
    // column k/4.
    function automatic logic [127:0] sub_byte(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++) begin
            o[127-8*k -: 8] = sbox(s[127-8*k -: 8]);
        end
        return o;
    endfunction

    // Row r rotates left by r columns: out(r,c) = in(r,(c+r)%4).
    function automatic logic [127:0] shift_row(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] mix_word(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_col(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = mix_word(s[127-32*c -: 32]);
        end
        return o;
    endfunction

    // One step of the AES-128 key schedule: RotWord, SubWord, XOR rcon,
    // then the four-word XOR cascade.
    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, rot, t;
        w0  = k[127:96];
        w1  = k[95:64];
        w2  = k[63:32];
        w3  = k[31:0];
        rot = {w3[23:0], w3[31:24]};
        t   = {sbox(rot[31:24]) ^ rc, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
        w0  = w0 ^ t;
        w1  = w1 ^ w0;
        w2  = w2 ^ w1;
        w3  = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] state_reg;
    logic [127:0] rkey_reg;
    logic [7:0]   rcon_reg;
    logic [3:0]   rnd;
    logic [3:0]   rnd_next;
    logic         accept;
    logic         final_step;
    logic [127:0] step_state;
    logic [127:0] step_key;
    logic [7:0]   step_rcon;

`ifdef AES_CBC_EN
    logic [127:0] chain;
    // iv_load takes the IDLE cycle, so the input side is not ready then.
    assign in_ready = (state_q == IDLE) && !iv_load;
`else
    assign in_ready = (state_q == IDLE);
`endif

    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign rnd_next   = rnd + 4'(UNROLL);
    assign final_step = (state_q == RUN) && (rnd_next == 4'd10);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (final_step) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Round datapath: each loop iteration is one physical round slot.
    // Round 10 (no MixColumns) is only ever the last slot of the final step.
    // ------------------------------------------------------------------

    always_comb begin : round_slots
        logic [127:0] s;
        logic [127:0] k;
        logic [127:0] t;
        logic [7:0]   rc;
        s  = state_reg;
        k  = rkey_reg;
        rc = rcon_reg;
        t  = '0;
        for (int i = 0; i < int'(UNROLL); i++) begin
            k  = key_step(k, rc);
            rc = xtime(rc);
            t  = shift_row(sub_byte(s));
            if ((i == int'(UNROLL) - 1) && final_step) s = t ^ k;
            else                                       s = mix_col(t) ^ k;
        end
        step_state = s;
        step_key   = k;
        step_rcon  = rc;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= '0;
            rkey_reg  <= '0;
            rcon_reg  <= '0;
            rnd       <= '0;
            data_out  <= '0;
`ifdef AES_CBC_EN
            chain     <= '0;
`endif
        end else begin
            if (accept) begin
`ifdef AES_CBC_EN
                state_reg <= data_in ^ chain ^ key_in;
`else
                state_reg <= data_in ^ key_in;
`endif
                rkey_reg  <= key_in;
                rcon_reg  <= RCON_INIT;
                rnd       <= '0;
            end else if (state_q == RUN) begin
                state_reg <= step_state;
                rkey_reg  <= step_key;
                rcon_reg  <= step_rcon;
                rnd       <= rnd_next;
                if (final_step) data_out <= step_state;
            end
`ifdef AES_CBC_EN
            if (state_q == IDLE && iv_load) chain <= iv_in;
            else if (state_q == DONE && out_ready) chain <= data_out;
`endif
        end
    end

endmodule

// File: tb/tb_aes128_enc_iter.sv
// tb_aes128_enc_iter: directed FIPS-197 vectors against aes128_enc_iter.
// The main instance (UNROLL=1) is driven through tasks; expected ciphertext
// and latency are queued when a block is issued and a monitor pops them when
// the DUT presents a result. Three extra instances cover UNROLL=2, 5, 10.

module tb_aes128_enc_iter;

    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] Z_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic [127:0] key_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;
    logic         busy;
`ifdef AES_CBC_EN
    logic [127:0] iv_in;
    logic         iv_load;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    aes128_enc_iter #(.UNROLL(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .key_in    (key_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
`ifdef AES_CBC_EN
        .iv_in     (iv_in),
        .iv_load   (iv_load),
`endif
        .busy      (busy)
    );

    // ---------------- bookkeeping ----------------
    int pass_cnt = 0;
    int chk_cnt  = 0;
    int var_done = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / monitor ----------------
    logic [127:0] exp_q[$];
    int           lat_q[$];
    int           acc_q[$];
    logic         ov_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            acc_q.delete();
            ov_prev = 1'b0;
        end else begin
            if (in_valid && in_ready) acc_q.push_back(cyc + 1);
            if (out_valid && !ov_prev) begin
                if (acc_q.size() == 0 || lat_q.size() == 0) chk("unexpected_out_valid", 1, 0);
                else chk("latency", cyc - acc_q.pop_front(), lat_q.pop_front());
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_result", data_out, 0);
                else chk("data_out", data_out, exp_q.pop_front());
            end
            ov_prev = out_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_accept();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 1, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] d, input logic [127:0] k,
                        input logic [127:0] exp, input int lat, input bit push);
`ifdef AES_CBC_EN
        iv_in   = '0;
        iv_load = 1'b1;
        @(posedge clk);
        #1;
        iv_load = 1'b0;
`endif
        data_in  = d;
        key_in   = k;
        in_valid = 1'b1;
        if (push) begin
            exp_q.push_back(exp);
            lat_q.push_back(lat);
        end
        wait_accept();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int acc1;
        int acc2;
        logic [127:0] d2;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        key_in    = '0;
`ifdef AES_CBC_EN
        iv_in     = '0;
        iv_load   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data_out", data_out, 0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // FIPS-197 App. C.1 and App. B with out_ready held high early.
        send(C_PT, C_KEY, C_CT, 10, 1);
        wait_idle();
        send(B_PT, B_KEY, B_CT, 10, 1);
        wait_idle();

        // Zero key/data; consumer stalls for 20 cycles, second block ignored.
        out_ready = 1'b0;
        send('0, '0, Z_CT, 10, 1);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk("hold_out_valid_timeout", 0, 1);
        data_in  = B_PT;
        key_in   = B_KEY;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_data_out", data_out, Z_CT);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_out_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Reset on the 4th RUN edge discards the block.
        send(B_PT, B_KEY, '0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_data_out", data_out, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_busy", busy, 0);
        @(posedge clk);
        #1;
        send(C_PT, C_KEY, C_CT, 10, 1);
        wait_idle();

        // Back-to-back with in_valid and out_ready held high.
`ifdef AES_CBC_EN
        iv_in   = '0;
        iv_load = 1'b1;
        @(posedge clk);
        #1;
        iv_load = 1'b0;
        d2 = C_PT ^ B_CT;   // chain holds B_CT after the first handoff
`else
        d2 = C_PT;
`endif
        data_in  = B_PT;
        key_in   = B_KEY;
        in_valid = 1'b1;
        exp_q.push_back(B_CT);
        lat_q.push_back(10);
        wait_accept();
        acc1 = cyc + 1;
        @(posedge clk);
        #1;
        data_in = d2;
        key_in  = C_KEY;
        exp_q.push_back(C_CT);
        lat_q.push_back(10);
        wait_accept();
        acc2 = cyc + 1;
        chk("b2b_period", acc2 - acc1, 12);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_idle();

`ifdef AES_CBC_EN
        // iv_load beats a simultaneous in_valid; the block goes in a cycle later.
        iv_in    = '0;
        iv_load  = 1'b1;
        data_in  = B_PT;
        key_in   = B_KEY;
        in_valid = 1'b1;
        @(negedge clk);
        chk("cbc_ivload_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        iv_load = 1'b0;
        chk("cbc_ivload_no_accept", busy, 0);
        exp_q.push_back(B_CT);
        lat_q.push_back(10);
        wait_accept();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_idle();
        send(C_PT ^ B_CT, C_KEY, C_CT, 10, 1);
        wait_idle();
`endif

        n = 0;
        while (var_done < 3 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("unroll_variants_done", var_done, 3);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    // ---------------- UNROLL = 2, 5, 10 instances ----------------
    for (genvar g = 0; g < 3; g++) begin : g_var
        localparam int U = (g == 0) ? 2 : ((g == 1) ? 5 : 10);
        logic         v_in_valid;
        logic         v_in_ready;
        logic         v_out_valid;
        logic         v_busy;
        logic [127:0] v_data_out;

        aes128_enc_iter #(.UNROLL(U)) dut_v (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (v_in_valid),
            .in_ready  (v_in_ready),
            .data_in   (C_PT),
            .key_in    (C_KEY),
            .out_valid (v_out_valid),
            .out_ready (1'b1),
            .data_out  (v_data_out),
`ifdef AES_CBC_EN
            .iv_in     (128'h0),
            .iv_load   (1'b0),
`endif
            .busy      (v_busy)
        );

        initial begin
            int acc;
            int n;
            v_in_valid = 1'b0;
            repeat (6) @(posedge clk);
            #1;
            v_in_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("u%0d_in_ready", U), v_in_ready, 1);
            acc = cyc + 1;
            @(posedge clk);
            #1;
            v_in_valid = 1'b0;
            n = 0;
            while (!v_out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("u%0d_latency", U), cyc - acc, 10 / U);
            chk($sformatf("u%0d_data_out", U), v_data_out, C_CT);
            @(negedge clk);
            chk($sformatf("u%0d_busy_after", U), v_busy, 0);
            var_done++;
        end
    end

endmodule

// File: doc/aes128_enc_iter.md
Name: aes128_enc_iter

Overview:
- Sequential, parametrised successor to the team's fully combinational AES-128 encryptor.
- Runs the 10 AES-128 rounds iteratively over a configurable number of cycles, trading area for latency. UNROLL sets the number of rounds per clock.
- Round keys are expanded on the fly; there is no 11-key precompute.
- Sits between the ticket/ID formatter and the storage/transmit path.
- Valid/ready handshake on input and on output.
- Reuses the existing sub_byte, shift_row and mix_col blocks, one set per unrolled round slot.

Parameters:
- UNROLL, 1, rounds executed per clock. Legal values: 1, 2, 5, 10. Any other value is an elaboration error.
- RCON_INIT, 8'h01, first round constant. Fixed by FIPS-197; exposed for test only.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  data_in/key_in are valid.
- in_ready  out  1  core is able to accept a block.
- data_in  in  128  plaintext block; bit 127 = first byte MSB (FIPS-197 byte order).
- key_in  in  128  cipher key, same byte order.
- out_valid  out  1  data_out holds a finished ciphertext.
- out_ready  in  1  consumer accepts data_out.
- data_out  out  128  ciphertext.
- busy  out  1  high in RUN and DONE.
- iv_in  in  128  chaining IV. Present only with AES_CBC_EN.
- iv_load  in  1  load IV into chain register. Present only with AES_CBC_EN.

Behaviour:
- States: IDLE, RUN, DONE. Reset (rst_n low at a clk edge) gives:
  - state = IDLE; in_ready = 1; out_valid = 0; busy = 0; data_out = 0.
  - round counter = 0; internal state/key registers = 0.
- IDLE:
  - in_ready = 1.
  - Accept when in_valid && in_ready at an edge (the accept edge): state_reg <= data_in ^ key_in (initial AddRoundKey); rkey_reg <= key_in; rcon_reg <= RCON_INIT; rnd <= 0; go to RUN.
- RUN:
  - in_ready = 0. in_valid is ignored; there is no queueing.
  - Each edge applies UNROLL consecutive rounds combinationally: slot i computes round r = rnd+i+1.
  - Round key for slot i is derived from the previous slot's key by: RotWord, SubWord (4 S-boxes), XOR rcon, then the word cascade.
  - rcon advances by xtime per round: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
  - Rounds 1-9 are SubBytes, ShiftRows, MixColumns, AddRoundKey. Round 10 omits MixColumns. Round 10 is always the last slot of the final step because UNROLL divides 10.
  - rnd <= rnd + UNROLL.
  - When rnd + UNROLL == 10: data_out <= result; out_valid <= 1; go to DONE.
- Latency: out_valid rises 10/UNROLL edges after the accept edge (10, 5, 2, 1). Throughput is one block per 10/UNROLL + 2 cycles.
- DONE:
  - out_valid = 1; data_out is held stable until out_ready.
  - On an edge with out_ready = 1: out_valid <= 0; go to IDLE.
  - in_ready stays 0 in DONE, so no same-cycle handoff. Next accept is possible at the edge after returning to IDLE.
  - data_out keeps its last value after the handoff; it is only meaningful while out_valid = 1.
- Boundary conditions:
  - out_ready held high before completion: no effect until DONE.
  - in_valid held high continuously: one block is accepted per IDLE visit.
  - rst_n low mid-RUN or in DONE: result is discarded and all outputs return to reset values on that edge. Reset has priority over every other event.
  - All-zero and all-ones key and data are legal; there are no special cases.

Optional Feature:
- AES_CBC_EN defined: adds iv_in, iv_load and a 128-bit chain register (reset 0).
  - iv_load = 1 at an edge in IDLE: chain <= iv_in. iv_load wins over a simultaneous in_valid, which is not accepted that cycle. iv_load is ignored outside IDLE.
  - At the accept edge: state_reg <= data_in ^ chain ^ key_in.
  - At the DONE→IDLE handoff edge: chain <= data_out.
- AES_CBC_EN undefined: pure ECB. No iv ports, no chain register; behaviour exactly as above.

Test Plan:
- FIPS-197 App. B, UNROLL=1: data 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c → data_out 3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 edges after accept.
- FIPS-197 App. C.1, UNROLL=1, 2, 5 and 10: data 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f → 69c4e0d86a7b0430d8cdb78070b4c55a, latency 10/5/2/1 respectively.
- Zero key and zero data → 66e94bd4ef8a2c3b884cfa59ca342b2e. Hold out_ready = 0 for 20 cycles: data_out stable, in_ready = 0, a second in_valid is ignored. Release out_ready: out_valid = 0 next cycle, in_ready = 1.
- Reset mid-run: accept App. B, pull rst_n low at 4th RUN edge → next cycle out_valid = 0, data_out = 0, in_ready = 1. A fresh App. C.1 block then gives the correct 69c4... result.
- Back-to-back: two blocks (App. B, then App. C.1) with in_valid and out_ready held high → results in order, second accept on the edge after the first handoff, block period 12 cycles at UNROLL=1.
- AES_CBC_EN: iv_load with iv_in = 0 and App. B → 3925841d.... Next block must equal ECB(data ^ 3925841d02dc09fbdc118597196a0b32) from the model. iv_load with simultaneous in_valid → no accept that cycle.
